// File: rtl/ctrl_pkg.sv
//------------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the RAM unload controller.
//   unload_state_t  : FSM states of ram_unload_ctrl
//   BYTES_PER_WORD  : bytes carried by one RAM word
//   BYTE_W          : width of one FIFO byte
//------------------------------------------------------------------------------
package ctrl_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_RAM,
        LATCH,
        SEND,
        CSUM,
        DONE
    } unload_state_t;

endpackage

// File: rtl/byte_serializer.sv
//------------------------------------------------------------------------------
// byte_serializer
// Holds one RAM word and hands it out one byte at a time, MSB first.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture data and restart the byte count
//   shift      : current byte has been consumed, advance to the next one
//   data       : word to serialize
//   byte_out   : byte currently presented (top byte of the shift register)
//   last_byte  : byte_out is the final byte of the word
//------------------------------------------------------------------------------
module byte_serializer
    import ctrl_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load,
    input  logic                             shift,
    input  logic [BYTES_PER_WORD*BYTE_W-1:0] data,
    output logic [BYTE_W-1:0]                byte_out,
    output logic                             last_byte
);

    localparam int unsigned WORD_W = BYTES_PER_WORD * BYTE_W;

    logic [WORD_W-1:0] shreg;
    logic [1:0]        byte_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shreg    <= data;
            byte_cnt <= '0;
        end else if (shift) begin
            shreg    <= {shreg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign byte_out  = shreg[WORD_W-1 -: BYTE_W];
    assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ram_unload_ctrl.sv
//------------------------------------------------------------------------------
// ram_unload_ctrl
// Reads words 0..NUM_WORDS-1 from the sample RAM and writes each one to the
// outbound byte FIFO as four bytes, MSB first.
// Optional feature: define UNLOAD_CHECKSUM_EN to append one byte holding the
// mod-256 sum of all data bytes after the last data byte.
// Parameters:
//   ADDR_W    : RAM address width
//   NUM_WORDS : words unloaded per start (1..2**ADDR_W)
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle unload request (ignored while busy)
//   fifo_full  : FIFO cannot accept a byte this cycle
//   ram_rdata  : RAM read data, valid the cycle after ram_rd
//   ram_rd     : RAM read strobe
//   ram_addr   : RAM read address
//   fifo_wr    : FIFO write strobe
//   fifo_wdata : byte presented to the FIFO
//   busy       : unload in progress
//   done       : one-cycle pulse after the final byte is written
//------------------------------------------------------------------------------
module ram_unload_ctrl
    import ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_full,
    input  logic [31:0]       ram_rdata,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              fifo_wr,
    output logic [7:0]        fifo_wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    unload_state_t     state, state_next;
    logic [ADDR_W-1:0] addr;
    logic              load, shift, last_byte;
    logic [7:0]        ser_byte;

    byte_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .data      (ram_rdata),
        .byte_out  (ser_byte),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        ram_rd     = 1'b0;
        fifo_wr    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RD_RAM;
            end
            RD_RAM: begin
                ram_rd     = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                load       = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (!fifo_full) begin
                    fifo_wr = 1'b1;
                    shift   = 1'b1;
                    if (last_byte) begin
                        if (addr == LAST_ADDR) begin
`ifdef UNLOAD_CHECKSUM_EN
                            state_next = CSUM;
`else
                            state_next = DONE;
`endif
                        end else begin
                            state_next = RD_RAM;
                        end
                    end
                end
            end
            CSUM: begin
`ifdef UNLOAD_CHECKSUM_EN
                if (!fifo_full) begin
                    fifo_wr    = 1'b1;
                    state_next = DONE;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address advances only after the last byte of a non-final word, so it
    // never passes LAST_ADDR and cannot wrap when NUM_WORDS == 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (state == DONE) begin
            addr <= '0;
        end else if (shift && last_byte && (addr != LAST_ADDR)) begin
            addr <= addr + 1'b1;
        end
    end

    assign ram_addr = addr;
    assign busy     = (state != IDLE);

`ifdef UNLOAD_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (state == IDLE && start) begin
            sum <= '0;
        end else if (shift) begin
            sum <= sum + ser_byte;
        end
    end

    assign fifo_wdata = (state == CSUM) ? sum : ser_byte;
`else
    assign fifo_wdata = ser_byte;
`endif

endmodule

// File: tb/tb_ram_unload_ctrl.sv
module tb_ram_unload_ctrl;

`ifdef UNLOAD_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    // Instance A: full address range (ADDR_W=2, NUM_WORDS=4)
    // Instance B: single word (ADDR_W=8, NUM_WORDS=1)
    localparam int A_NW = 4;
    localparam int B_NW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic        a_start, a_full, a_rd, a_wr, a_busy, a_done;
    logic [31:0] a_rdata;
    logic [1:0]  a_addr;
    logic [7:0]  a_wdata;
    logic [31:0] a_mem [0:3];

    ram_unload_ctrl #(.ADDR_W(2), .NUM_WORDS(A_NW)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .fifo_full(a_full),
        .ram_rdata(a_rdata), .ram_rd(a_rd), .ram_addr(a_addr),
        .fifo_wr(a_wr), .fifo_wdata(a_wdata), .busy(a_busy), .done(a_done)
    );

    // ---------------- instance B ----------------
    logic        b_start, b_full, b_rd, b_wr, b_busy, b_done;
    logic [31:0] b_rdata;
    logic [7:0]  b_addr;
    logic [7:0]  b_wdata;
    logic [31:0] b_mem [0:255];

    ram_unload_ctrl #(.ADDR_W(8), .NUM_WORDS(B_NW)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .fifo_full(b_full),
        .ram_rdata(b_rdata), .ram_rd(b_rd), .ram_addr(b_addr),
        .fifo_wr(b_wr), .fifo_wdata(b_wdata), .busy(b_busy), .done(b_done)
    );

    // RAM models: one-cycle read latency; garbage when not read
    always @(posedge clk) begin
        if (a_rd) a_rdata <= a_mem[a_addr];
        else      a_rdata <= $urandom;
        if (b_rd) b_rdata <= b_mem[b_addr];
        else      b_rdata <= $urandom;
    end

    // Monitors (sample at negedge, i.e. mid-cycle)
    logic [7:0] a_bytes[$], b_bytes[$];
    int         a_wcyc[$],  b_wcyc[$];
    int         a_raddr[$];
    int         a_done_cnt, b_done_cnt, a_done_cyc, b_done_cyc, b_rd_cnt;

    always @(negedge clk) begin
        if (a_wr) begin a_bytes.push_back(a_wdata); a_wcyc.push_back(cyc); end
        if (b_wr) begin b_bytes.push_back(b_wdata); b_wcyc.push_back(cyc); end
        if (a_rd) a_raddr.push_back(int'(a_addr));
        if (b_rd) b_rd_cnt = b_rd_cnt + 1;
        if (a_done) begin a_done_cnt = a_done_cnt + 1; a_done_cyc = cyc; end
        if (b_done) begin b_done_cnt = b_done_cnt + 1; b_done_cyc = cyc; end
    end

    task automatic clear_mon();
        a_bytes.delete(); b_bytes.delete();
        a_wcyc.delete();  b_wcyc.delete();
        a_raddr.delete();
        a_done_cnt = 0; b_done_cnt = 0; a_done_cyc = 0; b_done_cyc = 0; b_rd_cnt = 0;
    endtask

    // Reference: bytes in MSB-first order, optional trailing mod-256 sum
    function automatic void model_bytes(input logic [31:0] words[$], output logic [7:0] q[$]);
        int s = 0;
        q.delete();
        foreach (words[w]) begin
            for (int b = 0; b < 4; b++) begin
                int v = int'((words[w] >> (8 * (3 - b))) & 32'hFF);
                q.push_back(8'(v));
                s = (s + v) % 256;
            end
        end
        if (CS == 1) q.push_back(8'(s));
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_a_done(input int budget);
        int n = 0;
        while (a_done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
        total++;
        if (a_done_cnt == 0) begin
            bad++;
            $display("FAIL a_done_timeout: got no done in %0d cycles, want done", budget);
        end
    endtask

    task automatic wait_b_done(input int budget);
        int n = 0;
        while (b_done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
        total++;
        if (b_done_cnt == 0) begin
            bad++;
            $display("FAIL b_done_timeout: got no done in %0d cycles, want done", budget);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        reset = 1'b1;
        cycles(2);
        total++;
        if ({a_rd, a_addr, a_wr, a_wdata, a_busy, a_done} !== 14'd0) begin
            bad++;
            $display("FAIL reset_a_outputs: got %h want 0", {a_rd, a_addr, a_wr, a_wdata, a_busy, a_done});
        end
        total++;
        if ({b_rd, b_addr, b_wr, b_wdata, b_busy, b_done} !== 20'd0) begin
            bad++;
            $display("FAIL reset_b_outputs: got %h want 0", {b_rd, b_addr, b_wr, b_wdata, b_busy, b_done});
        end
        reset = 1'b0;
        cycles(1);

        // Reset in the middle of an unload
        for (int i = 0; i < 4; i++) a_mem[i] = $urandom;
        a_start = 1'b1; cycles(1); a_start = 1'b0;
        n = $urandom_range(3, 18);
        cycles(n);
        reset = 1'b1;
        cycles(1);
        total++;
        if ({a_rd, a_addr, a_wr, a_wdata, a_busy, a_done} !== 14'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want 0 (after %0d cycles)",
                     {a_rd, a_addr, a_wr, a_wdata, a_busy, a_done}, n);
        end
        cycles(1);
        reset = 1'b0;
        clear_mon();
        cycles(40);
        total++;
        if (a_bytes.size() != 0 || a_done_cnt != 0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet: got writes=%0d done=%0d busy=%b want 0/0/0",
                     a_bytes.size(), a_done_cnt, a_busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_word();
        logic [31:0] w[$];
        logic [7:0]  exp[$];
        int          st;
        b_mem[0] = 32'hDEADBEEF;
        w = '{32'hDEADBEEF};
        model_bytes(w, exp);
        clear_mon();
        b_start = 1'b1; st = cyc; cycles(1); b_start = 1'b0;
        wait_b_done(100);
        cycles(3);
        total++;
        if (b_bytes.size() != exp.size()) begin
            bad++;
            $display("FAIL single_count: got %0d want %0d", b_bytes.size(), exp.size());
        end
        foreach (exp[i]) begin
            if (i < b_bytes.size()) begin
                total++;
                if (b_bytes[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL single_byte[%0d]: got %02h want %02h", i, b_bytes[i], exp[i]);
                end
                total++;
                if (b_wcyc[i] != b_wcyc[0] + i) begin
                    bad++;
                    $display("FAIL single_consec[%0d]: got cycle %0d want %0d", i, b_wcyc[i], b_wcyc[0] + i);
                end
            end
        end
        total++;
        if (b_wcyc.size() == 0 || b_done_cyc != b_wcyc[b_wcyc.size()-1] + 1) begin
            bad++;
            $display("FAIL single_done_after_last: got done cycle %0d want last write + 1", b_done_cyc);
        end
        total++;
        if (b_done_cyc - st + 1 != 6 * B_NW + 2 + CS) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d", b_done_cyc - st + 1, 6 * B_NW + 2 + CS);
        end
        total++;
        if (b_done_cnt != 1 || b_rd_cnt != 1) begin
            bad++;
            $display("FAIL single_pulses: got done=%0d rd=%0d want 1/1", b_done_cnt, b_rd_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [31:0] w[$];
        logic [7:0]  exp[$];
        int          n = 0;
        b_mem[0] = 32'h01020304;
        w = '{32'h01020304};
        model_bytes(w, exp);
        clear_mon();
        b_start = 1'b1; cycles(1); b_start = 1'b0;
        while (b_bytes.size() < 1 && n < 50) begin cycles(1); n++; end
        b_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (b_wr !== 1'b0 || b_wdata !== 8'h02) begin
                bad++;
                $display("FAIL stall[%0d]: got wr=%b data=%02h want wr=0 data=02", i, b_wr, b_wdata);
            end
            @(posedge clk); #1;
        end
        b_full = 1'b0;
        wait_b_done(100);
        cycles(3);
        total++;
        if (b_bytes.size() != exp.size()) begin
            bad++;
            $display("FAIL bp_count: got %0d want %0d", b_bytes.size(), exp.size());
        end
        foreach (exp[i]) begin
            if (i < b_bytes.size()) begin
                total++;
                if (b_bytes[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL bp_byte[%0d]: got %02h want %02h", i, b_bytes[i], exp[i]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Whole address range with random backpressure; optional start pulses
    // while busy, which must be ignored.
    task automatic run_a(input string nm, input bit ramp, input bit poke_start);
        logic [31:0] w[$];
        logic [7:0]  exp[$];
        int          n = 0;
        w.delete();
        for (int i = 0; i < A_NW; i++) begin
            a_mem[i] = ramp ? 32'(i) : $urandom;
            w.push_back(a_mem[i]);
        end
        model_bytes(w, exp);
        clear_mon();
        a_start = 1'b1; cycles(1); a_start = 1'b0;
        while (a_done_cnt == 0 && n < 400) begin
            a_full  = ($urandom_range(0, 3) == 0);
            a_start = poke_start && (a_bytes.size() >= 2) && ($urandom_range(0, 4) == 0);
            cycles(1);
            n++;
        end
        a_full = 1'b0; a_start = 1'b0;
        wait_a_done(10);
        cycles(20);
        total++;
        if (a_bytes.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d want %0d", nm, a_bytes.size(), exp.size());
        end
        foreach (exp[i]) begin
            if (i < a_bytes.size()) begin
                total++;
                if (a_bytes[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s_byte[%0d]: got %02h want %02h", nm, i, a_bytes[i], exp[i]);
                end
            end
        end
        total++;
        if (a_raddr.size() != A_NW) begin
            bad++;
            $display("FAIL %s_reads: got %0d want %0d", nm, a_raddr.size(), A_NW);
        end
        foreach (a_raddr[i]) begin
            total++;
            if (a_raddr[i] != i) begin
                bad++;
                $display("FAIL %s_addr[%0d]: got %0d want %0d", nm, i, a_raddr[i], i);
            end
        end
        total++;
        if (a_done_cnt != 1 || a_busy !== 1'b0 || a_addr !== 2'd0) begin
            bad++;
            $display("FAIL %s_end: got done=%0d busy=%b addr=%0d want 1/0/0", nm, a_done_cnt, a_busy, a_addr);
        end
    endtask

    task automatic test_full_range();
        run_a("ramp", 1'b1, 1'b0);
        run_a("rand", 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_a("busy_start", 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) run_a("b2b", 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_full = 1'b0;
        b_start = 1'b0; b_full = 1'b0;
        for (int i = 0; i < 256; i++) b_mem[i] = 32'h0;
        for (int i = 0; i < 4; i++)   a_mem[i] = 32'h0;
        clear_mon();
        #1;
        test_reset();
        test_single_word();
        test_backpressure();
        test_full_range();
        test_start_while_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
